// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
//
// Feeds input/weight pairs from two synchronous-read RAMs to a double-precision
// multiplier, and collects each 64-bit product into a small first-word
// fall-through FIFO. The FIFO drains to a downstream accumulator as a
// valid/ready stream. The final product of each run is tagged with last.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   clk_en               clock enable; all state holds while low
//   start                begin a run (sampled only when idle)
//   length               number of pairs (latched on start)
//   x_base, w_base       vector base addresses (latched on start)
//   x_addr, w_addr       RAM read addresses (data returns one cycle later)
//   x_data, w_data       RAM read data
//   mult_compute         multiplier request, high for the whole ISSUE phase
//   mult_a, mult_b       multiplier operands (x, w)
//   mult_z               multiplier result
//   mult_complete        multiplier result valid
//   prod_valid/data/last product stream head
//   prod_ready           downstream accepts the head
//   busy                 high from accepted start until done
//   done                 one-cycle pulse once the run has fully drained

module dot_product_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              start,
  input  logic [ADDR_W-1:0] length,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] w_base,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [63:0]       x_data,
  input  logic [63:0]       w_data,
  output logic              mult_compute,
  output logic [63:0]       mult_a,
  output logic [63:0]       mult_b,
  input  logic [63:0]       mult_z,
  input  logic              mult_complete,
  output logic              prod_valid,
  output logic [63:0]       prod_data,
  output logic              prod_last,
  input  logic              prod_ready,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One extra bit so that a length of 2^ADDR_W-1 can be counted past.
  localparam int IDX_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_CAPTURE,
    S_GAP,
    S_DONE_WAIT
  } state_t;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } entry_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  len_q;
  logic [ADDR_W-1:0]  x_base_q;
  logic [ADDR_W-1:0]  w_base_q;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   len_ext;

  entry_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               is_last;
  entry_t             head;

  assign len_ext    = {1'b0, len_q};
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = prod_valid && prod_ready;
  // A full FIFO blocks the push even if a pop happens this cycle; the push
  // retries next cycle once the slot has actually been freed.
  assign push       = (state == S_CAPTURE) && !fifo_full;
  assign is_last    = (idx == len_ext - IDX_W'(1));

  // Addresses are driven continuously from the latched base and index. They
  // are stable through FETCH and LOAD, so a stalled LOAD still sees valid
  // RAM data.
  assign x_addr = x_base_q + idx[ADDR_W-1:0];
  assign w_addr = w_base_q + idx[ADDR_W-1:0];

  assign mult_compute = (state == S_ISSUE);

  assign head       = fifo_mem[rd_ptr];
  assign prod_valid = !fifo_empty;
  assign prod_data  = head.data;
  assign prod_last  = prod_valid && head.last;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = (length == '0) ? S_DONE_WAIT : S_FETCH;
      end
      S_FETCH:     state_next = S_LOAD;
      S_LOAD:      state_next = S_ISSUE;
      S_ISSUE: begin
        if (mult_complete) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!fifo_full) state_next = S_GAP;
      end
      S_GAP:       state_next = (idx < len_ext) ? S_FETCH : S_DONE_WAIT;
      S_DONE_WAIT: begin
        // An empty FIFO cannot have a pop in flight.
        if (fifo_empty) state_next = S_IDLE;
      end
      default:     state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state    <= S_IDLE;
      len_q    <= '0;
      x_base_q <= '0;
      w_base_q <= '0;
      idx      <= '0;
      mult_a   <= '0;
      mult_b   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (clk_en) begin
      state <= state_next;
      done  <= 1'b0;
      if (state == S_IDLE && start) begin
        len_q    <= length;
        x_base_q <= x_base;
        w_base_q <= w_base;
        idx      <= '0;
        busy     <= 1'b1;
      end
      if (state == S_LOAD) begin
        mult_a <= x_data;
        mult_b <= w_data;
      end
      if (push) idx <= idx + IDX_W'(1);
      if (state == S_DONE_WAIT && fifo_empty) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Product FIFO: pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clk_en) begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked entirely by
  // the pointers and count, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (clk_en && push) fifo_mem[wr_ptr] <= '{last: is_last, data: mult_z};
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer. It provides two RAM models,
// a behavioural double-precision multiplier with fixed latency, and a
// reference model that computes each run's product list directly from the
// RAM contents.

module tb_dot_product_sequencer;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int LAT    = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clk_en;
  logic              start;
  logic [ADDR_W-1:0] length;
  logic [ADDR_W-1:0] x_base;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] x_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [63:0]       x_data = '0;
  logic [63:0]       w_data = '0;
  logic              mult_compute;
  logic [63:0]       mult_a;
  logic [63:0]       mult_b;
  logic [63:0]       mult_z = '0;
  logic              mult_complete = 1'b0;
  logic              prod_valid;
  logic [63:0]       prod_data;
  logic              prod_last;
  logic              prod_ready;
  logic              busy;
  logic              done;

  dot_product_sequencer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start),
    .length(length), .x_base(x_base), .w_base(w_base),
    .x_addr(x_addr), .w_addr(w_addr), .x_data(x_data), .w_data(w_data),
    .mult_compute(mult_compute), .mult_a(mult_a), .mult_b(mult_b),
    .mult_z(mult_z), .mult_complete(mult_complete),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_last(prod_last),
    .prod_ready(prod_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAMs.
  logic [63:0] x_mem [256];
  logic [63:0] w_mem [256];
  always @(posedge clk) begin
    x_data <= x_mem[x_addr];
    w_data <= w_mem[w_addr];
  end

  // Multiplier: result appears LAT cycles into a request and stays stable
  // (complete held) until the request drops.
  int unsigned m_cnt = 0;
  always @(posedge clk) begin
    if (!mult_compute) begin
      m_cnt         <= 0;
      mult_complete <= 1'b0;
    end else if (m_cnt >= LAT - 1) begin
      mult_complete <= 1'b1;
      mult_z        <= $realtobits($bitstoreal(mult_a) * $bitstoreal(mult_b));
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Random clock-enable.
  logic clken_rand = 1'b0;
  initial forever begin
    @(negedge clk);
    clk_en = clken_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: samples just after each falling edge, once inputs have settled.
  typedef struct {
    logic [63:0] data;
    logic        last;
  } prod_t;

  prod_t       obs_q [$];
  prod_t       exp_q [$];
  logic [7:0]  xa_log [$];
  logic [7:0]  wa_log [$];
  logic [63:0] a_log [$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          rise_cnt = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          last_pop_cyc = 0;
  logic        prev_done = 1'b0;
  logic        prev_comp = 1'b0;

  initial forever begin
    @(negedge clk);
    #2;
    cyc++;
    if (rst_n) begin
      if (prod_valid && prod_ready && clk_en) begin
        obs_q.push_back('{prod_data, prod_last});
        last_pop_cyc = cyc;
      end
      if (done && !prev_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mult_compute && !prev_comp) begin
        rise_cnt++;
        xa_log.push_back(x_addr);
        wa_log.push_back(w_addr);
        a_log.push_back(mult_a);
      end
      if (start && !busy && clk_en) start_cyc = cyc;
    end
    prev_done = done;
    prev_comp = mult_compute;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  function automatic logic [63:0] rnd_val();
    return $realtobits((real'($urandom_range(0, 4000)) - 2000.0) / 8.0);
  endfunction

  task automatic reset_mon();
    obs_q.delete();
    xa_log.delete();
    wa_log.delete();
    a_log.delete();
    done_cnt = 0;
    rise_cnt = 0;
  endtask

  // Reference model: product i is x[xb+i] * w[wb+i] with 8-bit address wrap.
  task automatic build_exp(input int len, input int xb, input int wb);
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      real xv;
      real wv;
      xv = $bitstoreal(x_mem[(xb + i) % 256]);
      wv = $bitstoreal(w_mem[(wb + i) % 256]);
      exp_q.push_back('{$realtobits(xv * wv), (i == len - 1)});
    end
  endtask

  task automatic start_run(input int len, input int xb, input int wb);
    @(negedge clk);
    length = ADDR_W'(len);
    x_base = ADDR_W'(xb);
    w_base = ADDR_W'(wb);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("done_count", done_cnt, target);
  endtask

  task automatic compare_prods(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
      check($sformatf("%s_last%0d", tag, i), obs_q[i].last, exp_q[i].last);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    length     = '0;
    x_base     = '0;
    w_base     = '0;
    prod_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      x_mem[i] = rnd_val();
      w_mem[i] = rnd_val();
    end
    repeat (3) tick();

    // Reset state.
    check("rst_compute", mult_compute, 0);
    check("rst_a", mult_a, 0);
    check("rst_b", mult_b, 0);
    check("rst_x_addr", x_addr, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", prod_valid, 0);
    check("rst_last", prod_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed three-pair run with known constants.
    x_mem[8'h10] = 64'h3FF0000000000000;
    x_mem[8'h11] = 64'h4000000000000000;
    x_mem[8'h12] = 64'h4008000000000000;
    w_mem[8'h30] = 64'h4000000000000000;
    w_mem[8'h31] = 64'h3FE0000000000000;
    w_mem[8'h32] = 64'hBFF0000000000000;
    reset_mon();
    exp_q.delete();
    exp_q.push_back('{64'h4000000000000000, 1'b0});
    exp_q.push_back('{64'h3FF0000000000000, 1'b0});
    exp_q.push_back('{64'hC008000000000000, 1'b1});
    start_run(3, 8'h10, 8'h30);
    wait_done(1, 2000);
    repeat (10) tick();
    compare_prods("t1");
    check("t1_single_done", done_cnt, 1);
    check("t1_busy_after", busy, 0);

    // Zero length: nothing issued, done two cycles after start.
    reset_mon();
    start_run(0, 8'h00, 8'h00);
    wait_done(1, 50);
    check("t2_done_latency", done_cyc - start_cyc, 2);
    check("t2_no_compute", rise_cnt, 0);
    check("t2_no_products", obs_q.size(), 0);

    // Backpressure: FIFO fills, fifth pair parks in CAPTURE.
    reset_mon();
    @(negedge clk);
    prod_ready = 1'b0;
    build_exp(8, 8'h40, 8'h80);
    start_run(8, 8'h40, 8'h80);
    repeat (300) tick();
    check("t3_issued", rise_cnt, 5);
    check("t3_parked_compute", mult_compute, 0);
    check("t3_valid", prod_valid, 1);
    check("t3_head", prod_data, exp_q[0].data);
    check("t3_busy", busy, 1);
    check("t3_no_done", done_cnt, 0);
    @(negedge clk);
    prod_ready = 1'b1;
    wait_done(1, 2000);
    compare_prods("t3");
    check("t3_done_after_pop", done_cyc - last_pop_cyc, 2);

    // Address wrap.
    reset_mon();
    build_exp(4, 8'hFE, 8'h7F);
    start_run(4, 8'hFE, 8'h7F);
    wait_done(1, 2000);
    compare_prods("t4");
    check("t4_addr_count", xa_log.size(), 4);
    for (int i = 0; i < 4 && i < xa_log.size(); i++) begin
      logic [7:0] ex;
      logic [7:0] ew;
      ex = 8'hFE + 8'(i);
      ew = 8'h7F + 8'(i);
      check($sformatf("t4_x_addr%0d", i), xa_log[i], ex);
      check($sformatf("t4_w_addr%0d", i), wa_log[i], ew);
      check($sformatf("t4_mult_a%0d", i), a_log[i], x_mem[ex]);
    end

    // Reset during ISSUE of pair 2.
    reset_mon();
    start_run(4, 8'h40, 8'h50);
    begin
      int n;
      n = 0;
      while (!(rise_cnt >= 2 && mult_compute) && n < 500) begin
        tick();
        n++;
      end
      check("t5_reached_issue2", (rise_cnt >= 2 && mult_compute), 1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t5_compute", mult_compute, 0);
    check("t5_a", mult_a, 0);
    check("t5_x_addr", x_addr, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_valid", prod_valid, 0);
    check("t5_last", prod_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_mon();
    repeat (30) tick();
    check("t5_no_done", done_cnt, 0);
    reset_mon();
    build_exp(3, 8'h60, 8'h70);
    start_run(3, 8'h60, 8'h70);
    wait_done(1, 2000);
    compare_prods("t5_rerun");

    // Random clock-enable, ignored start pulses while busy.
    reset_mon();
    build_exp(5, 8'h90, 8'hA0);
    start_run(5, 8'h90, 8'hA0);
    clken_rand = 1'b1;
    for (int k = 0; k < 3; k++) begin
      repeat (7) tick();
      @(negedge clk);
      length = 8'd2;
      x_base = 8'h00;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
    end
    wait_done(1, 4000);
    clken_rand = 1'b0;
    repeat (30) tick();
    compare_prods("t6");
    check("t6_single_done", done_cnt, 1);
    check("t6_issued", rise_cnt, 5);
    check("t6_busy_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
